// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
// Optional build macro KEYPAD_REPEAT_EN is consumed by keypad_scanner only.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_e;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam logic [NUM_COLS-1:0] COL_IDLE  = 4'b1111;
    localparam logic [NUM_COLS-1:0] COL0_N    = 4'b1110;
    localparam logic [NUM_ROWS-1:0] ROWS_IDLE = 4'b1111;

    // Number of rows pulled low in an active-low row pattern.
    function automatic logic [2:0] count_low(input logic [NUM_ROWS-1:0] rows_n);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            n = n + {2'b00, ~rows_n[i]};
        end
        return n;
    endfunction

    // Index of the lowest-numbered row that is pulled low (0 when none are).
    function automatic logic [1:0] low_index(input logic [NUM_ROWS-1:0] rows_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            idx = rows_n[i] ? idx : 2'(i);
        end
        return idx;
    endfunction

    // One-hot active-low drive pattern for a column index.
    function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] idx);
        return COL_IDLE ^ (4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_scanner_tick.sv
// Scan-rate prescaler: emits a one-clk tick every DIV clocks.
module scan_tick_gen #(
    parameter int unsigned DIV = 32'h0000_0F00
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(DIV) + 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] ZERO   = CW'(0);

    logic [CW-1:0] cnt;

    // Down-counter that reloads on zero; tick is registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= ZERO;
            tick <= 1'b0;
        end else if (cnt == ZERO) begin
            cnt  <= RELOAD;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt - ONE;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad matrix scanner with debounce and ghost rejection.
// Define KEYPAD_REPEAT_EN to build the auto-repeat hold counter.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV           = 32'h0000_0F00,
    parameter int unsigned DEBOUNCE_SCANS     = 8,
    parameter int unsigned REPEAT_DELAY_SCANS = 500,
    parameter int unsigned REPEAT_RATE_SCANS  = 100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] ROW_N,
    output logic [NUM_COLS-1:0] COL_N,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                key_down
);

    localparam int DCW = $clog2(DEBOUNCE_SCANS) + 1;
    localparam logic [DCW-1:0] DEB_ZERO = DCW'(0);
    localparam logic [DCW-1:0] DEB_ONE  = DCW'(1);
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_SCANS - 1);
    localparam logic [DCW-1:0] DEB_FULL = DCW'(DEBOUNCE_SCANS);

    if (DEBOUNCE_SCANS < 1 || REPEAT_RATE_SCANS < 1 ||
        REPEAT_DELAY_SCANS < REPEAT_RATE_SCANS) begin : g_param_check
        $error("keypad_scanner: invalid scan parameters");
    end

    logic [NUM_ROWS-1:0] row_meta;
    logic [NUM_ROWS-1:0] row_sync;
    logic                tick;
    kp_state_e           state;
    logic [1:0]          col_idx;
    logic [1:0]          row_idx;
    logic [NUM_ROWS-1:0] row_pat;
    logic [DCW-1:0]      cnt;
    logic [DCW-1:0]      rel_cnt;

    logic [2:0]          n_low;
    logic [1:0]          low_idx;
    logic                rows_idle;
    logic [1:0]          col_next;
    logic [DCW-1:0]      cnt_inc;
    logic [DCW-1:0]      rel_inc;

`ifdef KEYPAD_REPEAT_EN
    localparam int HCW = $clog2(REPEAT_DELAY_SCANS) + 1;
    localparam logic [HCW-1:0] HOLD_ZERO  = HCW'(0);
    localparam logic [HCW-1:0] HOLD_ONE   = HCW'(1);
    localparam logic [HCW-1:0] HOLD_DELAY = HCW'(REPEAT_DELAY_SCANS);
    localparam logic [HCW-1:0] HOLD_RESUME = HCW'(REPEAT_DELAY_SCANS - REPEAT_RATE_SCANS);
    logic [HCW-1:0] hold_cnt;
    logic [HCW-1:0] hold_inc;
`endif

    scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchronizer for the asynchronous rows; idle rows read high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= ROWS_IDLE;
            row_sync <= ROWS_IDLE;
        end else begin
            row_meta <= ROW_N;
            row_sync <= row_meta;
        end
    end

    // Row decode and saturating counter increments.
    always_comb begin
        n_low     = count_low(row_sync);
        low_idx   = low_index(row_sync);
        rows_idle = (row_sync == ROWS_IDLE);
        col_next  = col_idx + 2'd1;
        cnt_inc   = (cnt >= DEB_FULL) ? cnt : cnt + DEB_ONE;
        rel_inc   = (rel_cnt >= DEB_FULL) ? rel_cnt : rel_cnt + DEB_ONE;
`ifdef KEYPAD_REPEAT_EN
        hold_inc  = (hold_cnt >= HOLD_DELAY) ? hold_cnt : hold_cnt + HOLD_ONE;
`endif
    end

    // Scan FSM with column shifter and registered key outputs; acts on ticks only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            COL_N     <= COL0_N;
            row_idx   <= 2'd0;
            row_pat   <= ROWS_IDLE;
            cnt       <= DEB_ZERO;
            rel_cnt   <= DEB_ZERO;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            hold_cnt  <= HOLD_ZERO;
`endif
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (n_low == 3'd1) begin
                            row_idx <= low_idx;
                            row_pat <= row_sync;
                            cnt     <= DEB_ZERO;
                            state   <= DEBOUNCE;
                        end else begin
                            col_idx <= col_next;
                            COL_N   <= col_drive(col_next);
                        end
                    end
                    DEBOUNCE: begin
                        if (row_sync == row_pat) begin
                            cnt <= cnt_inc;
                            if (cnt_inc >= DEB_LAST) begin
                                state     <= HELD;
                                key_code  <= {row_idx, col_idx};
                                key_valid <= 1'b1;
                                key_down  <= 1'b1;
                                rel_cnt   <= DEB_ZERO;
`ifdef KEYPAD_REPEAT_EN
                                hold_cnt  <= HOLD_ZERO;
`endif
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end else begin
                            col_idx <= col_next;
                            COL_N   <= col_drive(col_next);
                            state   <= SCAN;
                        end
                    end
                    HELD: begin
                        if (rows_idle) begin
                            rel_cnt <= rel_inc;
`ifdef KEYPAD_REPEAT_EN
                            hold_cnt <= HOLD_ZERO;
`endif
                            if (rel_inc >= DEB_FULL) begin
                                key_down <= 1'b0;
                                col_idx  <= col_next;
                                COL_N    <= col_drive(col_next);
                                state    <= SCAN;
                            end else begin
                                state <= HELD;
                            end
                        end else begin
                            rel_cnt <= DEB_ZERO;
`ifdef KEYPAD_REPEAT_EN
                            // After the first repeat, rewind so later repeats come every RATE ticks.
                            if (hold_inc >= HOLD_DELAY) begin
                                key_valid <= 1'b1;
                                hold_cnt  <= HOLD_RESUME;
                            end else begin
                                hold_cnt  <= hold_inc;
                            end
`endif
                        end
                    end
                    default: begin
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3).
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ROW_N;
    logic [3:0] COL_N;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic       k_en = 1'b0;
    logic [3:0] k_col_n = 4'hF;
    logic [3:0] k_rows_n = 4'hF;
    logic       f_en = 1'b0;
    logic [3:0] f_rows_n = 4'hF;

    int checks = 0;
    int errors = 0;
    int vcount = 0;
    int v0;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_EXP = 6;
`else
    localparam int REP_EXP = 1;
`endif

    typedef struct {
        logic [3:0] col_n;
        logic [3:0] rows_n;
        int         exp_valids;
        logic [3:0] exp_code;
        logic       exp_down;
    } vec_t;

    vec_t vecs [5];

    // Keypad model: a pressed key pulls its row low only while its column is driven.
    assign ROW_N = f_en ? f_rows_n : ((k_en && COL_N == k_col_n) ? k_rows_n : 4'hF);

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_valid === 1'b1) vcount++;
    end

    keypad_scanner #(
        .SCAN_DIV           (4),
        .DEBOUNCE_SCANS     (3),
        .REPEAT_DELAY_SCANS (10),
        .REPEAT_RATE_SCANS  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ROW_N     (ROW_N),
        .COL_N     (COL_N),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * 4) @(negedge clk);
    endtask

    task automatic wait_col_change(input string name);
        logic [3:0] c0;
        logic       seen;
        c0   = COL_N;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (COL_N != c0) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_key_down(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 48 && !seen; i++) begin
            @(negedge clk);
            if (key_down === 1'b1) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        vecs[0] = '{col_n: 4'b0111, rows_n: 4'b0111, exp_valids: 1, exp_code: 4'hF, exp_down: 1'b1};
        vecs[1] = '{col_n: 4'b1101, rows_n: 4'b1101, exp_valids: 1, exp_code: 4'h5, exp_down: 1'b1};
        vecs[2] = '{col_n: 4'b1011, rows_n: 4'b1101, exp_valids: 1, exp_code: 4'h6, exp_down: 1'b1};
        vecs[3] = '{col_n: 4'b1011, rows_n: 4'b0101, exp_valids: 0, exp_code: 4'h6, exp_down: 1'b0};
        vecs[4] = '{col_n: 4'b1110, rows_n: 4'b1110, exp_valids: 1, exp_code: 4'h0, exp_down: 1'b1};

        // Reset state and free-running column rotation.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_col", 32'(COL_N), 32'h0000000E);
        check("rst_code", 32'(key_code), 32'd0);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_down", 32'(key_down), 32'd0);
        wait_col_change("rot_start");
        check("rot_c1", 32'(COL_N), 32'h0000000D);
        repeat (4) @(negedge clk);
        check("rot_c2", 32'(COL_N), 32'h0000000B);
        repeat (4) @(negedge clk);
        check("rot_c3", 32'(COL_N), 32'h00000007);
        repeat (4) @(negedge clk);
        check("rot_c0", 32'(COL_N), 32'h0000000E);

        // Key 9 (row 2, column 1) held 20 ticks then released.
        v0 = vcount;
        k_col_n = 4'b1101; k_rows_n = 4'b1011; k_en = 1'b1;
        wait_ticks(20);
        check("k9_valids", 32'(vcount - v0), 32'd1);
        check("k9_code", 32'(key_code), 32'h9);
        check("k9_down", 32'(key_down), 32'd1);
        check("k9_frozen", 32'(COL_N), 32'h0000000D);
        k_en = 1'b0;
        wait_ticks(5);
        check("k9_release", 32'(key_down), 32'd0);
        wait_col_change("k9_resume");
        check("k9_valids_after", 32'(vcount - v0), 32'd1);

        // Table of single presses and a ghost pair.
        for (int i = 0; i < 5; i++) begin
            v0 = vcount;
            k_col_n = vecs[i].col_n; k_rows_n = vecs[i].rows_n; k_en = 1'b1;
            wait_ticks(12);
            check($sformatf("vec%0d_valids", i), 32'(vcount - v0), 32'(vecs[i].exp_valids));
            check($sformatf("vec%0d_code", i), 32'(key_code), 32'(vecs[i].exp_code));
            check($sformatf("vec%0d_down", i), 32'(key_down), 32'(vecs[i].exp_down));
            if (vecs[i].exp_down) check($sformatf("vec%0d_frozen", i), 32'(COL_N), 32'(vecs[i].col_n));
            else wait_col_change($sformatf("vec%0d_rotating", i));
            k_en = 1'b0;
            wait_ticks(6);
            check($sformatf("vec%0d_release", i), 32'(key_down), 32'd0);
        end

        // Bounce on row 0: low, high, low for one tick each.
        v0 = vcount;
        f_rows_n = 4'b1110; f_en = 1'b1;
        repeat (4) @(negedge clk);
        f_rows_n = 4'b1111;
        repeat (4) @(negedge clk);
        f_rows_n = 4'b1110;
        repeat (4) @(negedge clk);
        f_en = 1'b0;
        wait_ticks(8);
        check("bounce_valids", 32'(vcount - v0), 32'd0);
        check("bounce_down", 32'(key_down), 32'd0);
        check("bounce_code", 32'(key_code), 32'h0);
        wait_col_change("bounce_resume");

        // Key 0 held about 30 ticks: one pulse, or repeats when enabled.
        v0 = vcount;
        k_col_n = 4'b1110; k_rows_n = 4'b1110; k_en = 1'b1;
        wait_key_down("hold_accept");
        repeat (28 * 4) @(negedge clk);
        k_en = 1'b0;
        wait_ticks(6);
        check("hold_valids", 32'(vcount - v0), 32'(REP_EXP));
        check("hold_code", 32'(key_code), 32'h0);

        // Asynchronous reset while HELD, then a normal re-press.
        v0 = vcount;
        k_col_n = 4'b1101; k_rows_n = 4'b1011; k_en = 1'b1;
        wait_key_down("ar_accept");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("ar_col", 32'(COL_N), 32'h0000000E);
        check("ar_code", 32'(key_code), 32'd0);
        check("ar_valid", 32'(key_valid), 32'd0);
        check("ar_down", 32'(key_down), 32'd0);
        k_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_ticks(4);
        check("ar_no_pulse", 32'(vcount - v0), 32'd1);
        k_en = 1'b1;
        wait_ticks(12);
        check("ar_repress_valids", 32'(vcount - v0), 32'd2);
        check("ar_repress_code", 32'(key_code), 32'h9);
        check("ar_repress_down", 32'(key_down), 32'd1);
        k_en = 1'b0;
        wait_ticks(6);
        check("ar_repress_release", 32'(key_down), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
